// File: rtl/sort_stream_out.sv
// Captures a packed sorted vector on load and streams it one element per beat
// over valid/ready with a last marker; a load on the final beat chains vectors.
module sort_stream_out #(
  parameter int BITWIDTH  = 3,
  parameter int NUM_ELEMS = 8,
  parameter int DESCEND   = 0
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          load,
  input  logic [NUM_ELEMS*BITWIDTH-1:0] din_vec,
  output logic [BITWIDTH-1:0]           dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic                          dout_last,
  output logic                          busy,
  output logic                          load_drop
);

  localparam int VEC_W = NUM_ELEMS * BITWIDTH;
  localparam int IDX_W = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
  localparam logic [IDX_W-1:0] FIRST_IDX = (DESCEND != 0) ? IDX_W'(NUM_ELEMS - 1) : '0;
  localparam logic [IDX_W-1:0] LAST_IDX  = (DESCEND != 0) ? '0 : IDX_W'(NUM_ELEMS - 1);

  // Handshake: a beat is dout_valid & dout_ready at posedge clk. While valid
  // is high and ready is low, dout, dout_last and the index hold.
  typedef enum logic {IDLE, STREAM} state_t;

  state_t               state_q, state_d;
  logic [VEC_W-1:0]     cap_q, cap_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     idx_step;
  logic [BITWIDTH-1:0]  dout_q, dout_d;
  logic                 dout_last_q, dout_last_d;
  logic                 load_drop_q, load_drop_d;

  function automatic logic [BITWIDTH-1:0] elem(input logic [VEC_W-1:0] v,
                                               input logic [IDX_W-1:0] i);
    return v[i*BITWIDTH +: BITWIDTH];
  endfunction

  always_comb begin
    state_d     = state_q;
    cap_d       = cap_q;
    idx_d       = idx_q;
    dout_d      = dout_q;
    dout_last_d = dout_last_q;
    load_drop_d = 1'b0;
    idx_step    = (DESCEND != 0) ? idx_q - IDX_W'(1) : idx_q + IDX_W'(1);
    case (state_q)
      IDLE: begin
        if (load) begin
          cap_d       = din_vec;
          idx_d       = FIRST_IDX;
          dout_d      = elem(din_vec, FIRST_IDX);
          dout_last_d = 1'b0;
          state_d     = STREAM;
        end
      end
      STREAM: begin
        if (dout_ready && dout_last_q) begin
          // Final beat: a concurrent load chains the next vector with no bubble.
          if (load) begin
            cap_d       = din_vec;
            idx_d       = FIRST_IDX;
            dout_d      = elem(din_vec, FIRST_IDX);
            dout_last_d = 1'b0;
          end else begin
            dout_last_d = 1'b0;
            state_d     = IDLE;
          end
        end else if (dout_ready) begin
          idx_d       = idx_step;
          dout_d      = elem(cap_q, idx_step);
          dout_last_d = (idx_step == LAST_IDX);
          load_drop_d = load;
        end else begin
          load_drop_d = load;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cap_q       <= '0;
      idx_q       <= '0;
      dout_q      <= '0;
      dout_last_q <= 1'b0;
      load_drop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cap_q       <= cap_d;
      idx_q       <= idx_d;
      dout_q      <= dout_d;
      dout_last_q <= dout_last_d;
      load_drop_q <= load_drop_d;
    end
  end

  assign dout       = dout_q;
  assign dout_last  = dout_last_q;
  assign dout_valid = (state_q == STREAM);
  assign busy       = (state_q == STREAM);
  assign load_drop  = load_drop_q;

endmodule

// File: tb/tb_sort_stream_out.sv
// Bench for sort_stream_out: ascending and descending instances, scoreboard
// of {last, element} pairs checked on every observed beat.
module tb_sort_stream_out;
  localparam int BW = 3;
  localparam int NE = 8;
  localparam int VW = BW * NE;

  logic          clk;
  logic          resetn;
  logic          load, ready;
  logic [VW-1:0] din;
  logic [BW-1:0] dout;
  logic          valid, last, busy, drop;
  logic          load_b, ready_b;
  logic [VW-1:0] din_b;
  logic [BW-1:0] dout_b;
  logic          valid_b, last_b, busy_b, drop_b;

  logic [BW:0] exp_q[$];
  logic [BW:0] exp_b_q[$];
  int check_cnt = 0;
  int pass_cnt  = 0;

  logic [VW-1:0] vec_a, vec_b, vec_c;

  sort_stream_out #(.BITWIDTH(BW), .NUM_ELEMS(NE), .DESCEND(0)) dut (
    .clk(clk), .resetn(resetn), .load(load), .din_vec(din), .dout(dout),
    .dout_valid(valid), .dout_ready(ready), .dout_last(last), .busy(busy),
    .load_drop(drop));

  sort_stream_out #(.BITWIDTH(BW), .NUM_ELEMS(NE), .DESCEND(1)) dut_b (
    .clk(clk), .resetn(resetn), .load(load_b), .din_vec(din_b), .dout(dout_b),
    .dout_valid(valid_b), .dout_ready(ready_b), .dout_last(last_b), .busy(busy_b),
    .load_drop(drop_b));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [VW-1:0] pack(input int e0, e1, e2, e3, e4, e5, e6, e7);
    logic [VW-1:0] v;
    int e[8];
    e = '{e0, e1, e2, e3, e4, e5, e6, e7};
    v = '0;
    for (int i = 0; i < NE; i++) v[i*BW +: BW] = BW'(e[i]);
    return v;
  endfunction

  // Expected emission order follows DESCEND; only the final element has last=1.
  task automatic push_vec(input logic [VW-1:0] v, input bit desc);
    int idx;
    for (int k = 0; k < NE; k++) begin
      idx = desc ? NE - 1 - k : k;
      if (desc) exp_b_q.push_back({(k == NE - 1), v[idx*BW +: BW]});
      else      exp_q.push_back({(k == NE - 1), v[idx*BW +: BW]});
    end
  endtask

  // scoreboard monitors: a beat is valid & ready with reset released
  always @(negedge clk) begin
    logic [BW:0] e;
    if (resetn && valid && ready) begin
      check_cnt++;
      if (exp_q.size() == 0) $display("FAIL beat_asc: unexpected beat dout=%0d last=%0b", dout, last);
      else begin
        e = exp_q.pop_front();
        if ({last, dout} !== e) $display("FAIL beat_asc: got last=%0b dout=%0d, expected last=%0b dout=%0d", last, dout, e[BW], e[BW-1:0]);
        else pass_cnt++;
      end
    end
    if (resetn && valid_b && ready_b) begin
      check_cnt++;
      if (exp_b_q.size() == 0) $display("FAIL beat_desc: unexpected beat dout=%0d last=%0b", dout_b, last_b);
      else begin
        e = exp_b_q.pop_front();
        if ({last_b, dout_b} !== e) $display("FAIL beat_desc: got last=%0b dout=%0d, expected last=%0b dout=%0d", last_b, dout_b, e[BW], e[BW-1:0]);
        else pass_cnt++;
      end
    end
  end

  // driver: one-cycle load pulse; returns just after the sampling edge
  task automatic load_vec(input logic [VW-1:0] v);
    @(posedge clk); #1;
    load = 1'b1; din = v;
    push_vec(v, 1'b0);
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    check_cnt++;
    if ({valid, busy} !== 2'b00) $display("FAIL %s: valid=%0b busy=%0b, expected 0 0", name, valid, busy);
    else pass_cnt++;
    check_cnt++;
    if (exp_q.size() != 0) $display("FAIL %s: %0d expected beats not seen, expected 0", name, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset();
    resetn = 1'b0; load = 1'b0; ready = 1'b0; din = '0;
    load_b = 1'b0; ready_b = 1'b0; din_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_cnt++;
    if ({dout, valid, last, busy, drop} !== '0)
      $display("FAIL reset: dout=%0d valid=%0b last=%0b busy=%0b drop=%0b, expected all 0", dout, valid, last, busy, drop);
    else pass_cnt++;
    check_cnt++;
    if ({dout_b, valid_b, busy_b} !== '0) $display("FAIL reset_desc: dout=%0d valid=%0b busy=%0b, expected all 0", dout_b, valid_b, busy_b);
    else pass_cnt++;
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic test_basic();
    ready = 1'b1;
    load_vec(vec_a);
    for (int i = 0; i < NE; i++) begin
      @(negedge clk);
      check_cnt++;
      if (valid !== 1'b1) $display("FAIL basic_valid: cycle %0d valid=%0b, expected 1", i, valid);
      else pass_cnt++;
      if (i == 0) begin
        check_cnt++;
        if (drop !== 1'b0) $display("FAIL basic_idle_load: load_drop=%0b, expected 0", drop);
        else pass_cnt++;
      end
      @(posedge clk); #1;
    end
    check_idle("basic_end");
  endtask

  task automatic test_backpressure();
    int beats;
    logic prev_ready;
    logic [BW-1:0] prev_dout;
    logic [1:0] prev_meta;
    beats = 0; prev_ready = 1'b1; prev_dout = '0; prev_meta = '0;
    load_vec(vec_a);
    for (int k = 0; k < 40 && beats < NE; k++) begin
      ready = (k % 3 == 0);
      @(negedge clk);
      if (valid && !prev_ready) begin
        check_cnt++;
        if ({dout, last} !== {prev_dout, prev_meta[0]})
          $display("FAIL hold: dout=%0d last=%0b, expected held dout=%0d last=%0b", dout, last, prev_dout, prev_meta[0]);
        else pass_cnt++;
      end
      if (valid && ready) beats++;
      prev_ready = ready; prev_dout = dout; prev_meta = {1'b0, last};
      @(posedge clk); #1;
    end
    ready = 1'b1;
    check_cnt++;
    if (beats != NE) $display("FAIL bp_beats: %0d beats, expected %0d", beats, NE);
    else pass_cnt++;
    check_idle("bp_end");
  endtask

  task automatic test_drop();
    ready = 1'b1;
    load_vec(vec_a);
    for (int i = 0; i < NE; i++) begin
      load = (i == 3);
      din  = vec_b;
      @(negedge clk);
      if (i == 4 || i == 5) begin
        check_cnt++;
        if (drop !== (i == 4)) $display("FAIL load_drop: cycle %0d load_drop=%0b, expected %0b", i, drop, (i == 4));
        else pass_cnt++;
      end
      @(posedge clk); #1;
    end
    load = 1'b0;
    check_idle("drop_end");
  endtask

  task automatic test_back_to_back();
    ready = 1'b1;
    load_vec(vec_a);
    for (int i = 0; i < NE; i++) begin
      if (i == NE - 1) begin
        load = 1'b1; din = vec_c;
        push_vec(vec_c, 1'b0);
      end
      @(negedge clk);
      @(posedge clk); #1;
    end
    load = 1'b0;
    for (int i = 0; i < NE; i++) begin
      @(negedge clk);
      check_cnt++;
      if (valid !== 1'b1) $display("FAIL b2b_valid: cycle %0d valid=%0b, expected 1", i, valid);
      else pass_cnt++;
      if (i == 0) begin
        check_cnt++;
        if (drop !== 1'b0) $display("FAIL b2b_drop: load_drop=%0b, expected 0", drop);
        else pass_cnt++;
      end
      @(posedge clk); #1;
    end
    check_idle("b2b_end");
  endtask

  task automatic test_reset_mid();
    ready = 1'b1;
    load_vec(vec_a);
    repeat (4) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check_cnt++;
    if ({valid, busy, dout, last} !== '0) $display("FAIL mid_reset: valid=%0b busy=%0b dout=%0d last=%0b, expected all 0", valid, busy, dout, last);
    else pass_cnt++;
    check_cnt++;
    if (exp_q.size() != NE - 4) $display("FAIL mid_reset_beats: %0d elements left, expected %0d", exp_q.size(), NE - 4);
    else pass_cnt++;
    exp_q.delete();
    load_vec(vec_c);
    repeat (NE) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    check_idle("restart_end");
  endtask

  task automatic test_descend();
    ready_b = 1'b1;
    @(posedge clk); #1;
    load_b = 1'b1; din_b = vec_a;
    push_vec(vec_a, 1'b1);
    @(posedge clk); #1;
    load_b = 1'b0;
    for (int i = 0; i < NE; i++) begin
      @(negedge clk);
      check_cnt++;
      if (valid_b !== 1'b1) $display("FAIL desc_valid: cycle %0d valid=%0b, expected 1", i, valid_b);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    check_cnt++;
    if ({valid_b, busy_b} !== 2'b00 || exp_b_q.size() != 0)
      $display("FAIL desc_end: valid=%0b busy=%0b left=%0d, expected 0 0 0", valid_b, busy_b, exp_b_q.size());
    else pass_cnt++;
  endtask

  initial begin
    vec_a = pack(1, 1, 2, 3, 4, 4, 5, 7);
    vec_b = pack(6, 6, 6, 6, 6, 6, 6, 6);
    vec_c = pack(0, 0, 1, 2, 4, 7, 7, 7);
    test_reset();
    test_basic();
    test_backpressure();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    test_descend();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
